// File: rtl/dense_argmax.sv
// ---------------------------------------------------------------------------
// dense_argmax
//   Sequential argmax over a vector of B signed logits. A vector is captured
//   in one cycle and then scanned one lane per clock. The index and value of
//   the largest lane are published with a one-cycle valid pulse. Ties keep
//   the lower index. Vectors that arrive while a scan is running are
//   discarded, and this sets a sticky drop flag.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous, active-high reset
//   valid_i  in   one-cycle pulse: data_i holds a new vector
//   data_i   in   B*DATA_WIDTH packed signed lanes, lane k at [k*DW +: DW]
//   class_o  out  IDX_W   index of the maximum lane of the last vector
//   max_o    out  DW      signed value of that lane
//   valid_o  out  1       one-cycle pulse per accepted vector
//   busy_o   out  1       high while a vector is being scanned
//   drop_o   out  1       sticky: a vector arrived while busy and was lost
// ---------------------------------------------------------------------------
module dense_argmax #(
    parameter  int B          = 7,
    parameter  int DATA_WIDTH = 8,
    localparam int IDX_W      = (B > 1) ? $clog2(B) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    input  logic [B*DATA_WIDTH-1:0]   data_i,
    output logic [IDX_W-1:0]          class_o,
    output logic [DATA_WIDTH-1:0]     max_o,
    output logic                      valid_o,
    output logic                      busy_o,
    output logic                      drop_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(B - 1);
    localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);

    state_t                             state_q,    state_d;
    logic [B-1:0][DATA_WIDTH-1:0]       buf_q,      buf_d;
    logic [IDX_W-1:0]                   cnt_q,      cnt_d;
    logic [DATA_WIDTH-1:0]              best_val_q, best_val_d;
    logic [IDX_W-1:0]                   best_idx_q, best_idx_d;
    logic [IDX_W-1:0]                   class_q,    class_d;
    logic [DATA_WIDTH-1:0]              max_q,      max_d;
    logic                               valid_q,    valid_d;
    logic                               drop_q,     drop_d;

    logic [DATA_WIDTH-1:0]              lane_s;
    logic [DATA_WIDTH-1:0]              lane0_s;
    logic [DATA_WIDTH-1:0]              next_val_s;
    logic [IDX_W-1:0]                   next_idx_s;

    // Compare datapath: the buffered lane under the counter against the running best.
    always_comb begin
        lane_s  = buf_q[cnt_q];
        lane0_s = data_i[DATA_WIDTH-1:0];
        // Strictly greater replaces; equality keeps the earlier (lower) index.
        if ($signed(lane_s) > $signed(best_val_q)) begin
            next_val_s = lane_s;
            next_idx_s = cnt_q;
        end else begin
            next_val_s = best_val_q;
            next_idx_s = best_idx_q;
        end
    end

    // Next-state logic for the FSM, scan counter, running best and outputs.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        class_d    = class_q;
        max_d      = max_q;
        valid_d    = 1'b0;
        drop_d     = drop_q;

        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    buf_d = data_i;
                    if (B == 1) begin
                        // A single lane is its own maximum: publish at once.
                        class_d = {IDX_W{1'b0}};
                        max_d   = lane0_s;
                        valid_d = 1'b1;
                    end else begin
                        best_val_d = lane0_s;
                        best_idx_d = {IDX_W{1'b0}};
                        cnt_d      = ONE_IDX;
                        state_d    = ST_SCAN;
                    end
                end else begin
                    buf_d = buf_q;
                end
            end

            ST_SCAN: begin
                // The buffer is frozen during a scan; any new vector is lost.
                if (valid_i) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end

                best_val_d = next_val_s;
                best_idx_d = next_idx_s;

                if (cnt_q == LAST_LANE) begin
                    class_d = next_idx_s;
                    max_d   = next_val_s;
                    valid_d = 1'b1;
                    cnt_d   = {IDX_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + ONE_IDX;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {IDX_W{1'b0}};
            best_val_q <= {DATA_WIDTH{1'b0}};
            best_idx_q <= {IDX_W{1'b0}};
            class_q    <= {IDX_W{1'b0}};
            max_q      <= {DATA_WIDTH{1'b0}};
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            class_q    <= class_d;
            max_q      <= max_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
        end
    end

    // Vector buffer; its contents are meaningless after reset so it carries none.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign class_o = class_q;
    assign max_o   = max_q;
    assign valid_o = valid_q;
    assign drop_o  = drop_q;
    assign busy_o  = (state_q == ST_SCAN);

    dense_argmax_chk #(
        .B          (B),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy_o),
        .valid   (valid_o),
        .class_v (class_o),
        .max_v   (max_o),
        .cnt     (cnt_q)
    );

endmodule

// ---------------------------------------------------------------------------
// dense_argmax_chk
//   Simulation-time invariants for dense_argmax: the lane counter stays in
//   range and the published result does not move during a scan.
//
// Ports
//   clk, rst          clock and synchronous reset of the host block
//   busy, valid       host busy_o / valid_o
//   class_v, max_v    host class_o / max_o
//   cnt               host lane counter
// ---------------------------------------------------------------------------
module dense_argmax_chk #(
    parameter int B          = 7,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  busy,
    input  logic                  valid,
    input  logic [IDX_W-1:0]      class_v,
    input  logic [DATA_WIDTH-1:0] max_v,
    input  logic [IDX_W-1:0]      cnt
);

    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(B - 1);

    logic                  prev_busy_q;
    logic                  prev_rst_q;
    logic [IDX_W-1:0]      prev_class_q;
    logic [DATA_WIDTH-1:0] prev_max_q;

    // Remember the previous sample so stability can be checked across one edge.
    always_ff @(posedge clk) begin
        prev_busy_q  <= busy;
        prev_rst_q   <= rst;
        prev_class_q <= class_v;
        prev_max_q   <= max_v;
    end

    // Invariants, evaluated on every edge outside reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (cnt <= LAST_LANE);
            if (prev_busy_q && !prev_rst_q && !valid) begin
                assert ((class_v == prev_class_q) && (max_v == prev_max_q));
            end
        end
    end

endmodule

// File: tb/tb_dense_argmax.sv
// ---------------------------------------------------------------------------
// tb_dense_argmax
//   Directed scenarios plus 10,000 random vectors for dense_argmax (B=7,
//   DATA_WIDTH=8). A reference model predicts every output on every cycle.
//   It uses edge arithmetic: a vector accepted at edge e is due at e+B-1, and
//   the block is free again from e+B. It computes a plain argmax loop over
//   the lanes. Literal checks pin the model on the hand-computed cases.
// ---------------------------------------------------------------------------
module tb_dense_argmax;

    localparam int B  = 7;
    localparam int DW = 8;
    localparam int IW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_i;
    logic [B*DW-1:0]   data_i;
    logic [IW-1:0]     class_o;
    logic [DW-1:0]     max_o;
    logic              valid_o;
    logic              busy_o;
    logic              drop_o;

    always #5 clk = ~clk;

    dense_argmax #(.B(B), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .data_i  (data_i),
        .class_o (class_o),
        .max_o   (max_o),
        .valid_o (valid_o),
        .busy_o  (busy_o),
        .drop_o  (drop_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    longint edge_n    = 0;
    longint free_edge = 0;
    longint due_edge  = 0;
    bit     pending   = 1'b0;
    int     pend_class, pend_max;
    int     m_class = 0, m_max = 0;
    bit     m_valid = 1'b0, m_busy = 1'b0, m_drop = 1'b0;

    int lane_v [B];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
        end
    endtask

    // Reference model: evaluate what the edge just taken must have produced.
    task automatic model_edge();
        int v;
        edge_n++;
        m_valid = 1'b0;
        if (rst) begin
            pending   = 1'b0;
            m_class   = 0;
            m_max     = 0;
            m_drop    = 1'b0;
            free_edge = edge_n + 1;
        end else begin
            if (valid_i) begin
                if (edge_n >= free_edge) begin
                    pend_class = 0;
                    pend_max   = $signed(data_i[DW-1:0]);
                    for (int k = 1; k < B; k++) begin
                        v = $signed(data_i[k*DW +: DW]);
                        if (v > pend_max) begin
                            pend_max   = v;
                            pend_class = k;
                        end
                    end
                    due_edge  = edge_n + B - 1;
                    free_edge = edge_n + B;
                    pending   = 1'b1;
                end else begin
                    m_drop = 1'b1;
                end
            end
            if (pending && due_edge == edge_n) begin
                m_class = pend_class;
                m_max   = pend_max;
                m_valid = 1'b1;
                pending = 1'b0;
            end
        end
        m_busy = pending;
    endtask

    task automatic check_all();
        check("valid_o", int'(valid_o), int'(m_valid));
        check("busy_o",  int'(busy_o),  int'(m_busy));
        check("drop_o",  int'(drop_o),  int'(m_drop));
        check("class_o", int'(class_o), m_class);
        check("max_o",   int'($signed(max_o)), m_max);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse();
        for (int k = 0; k < B; k++) begin
            data_i[k*DW +: DW] = lane_v[k][DW-1:0];
        end
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic lit_result(input string name, input int cls, input int mx);
        check({name, "_valid"}, int'(valid_o), 1);
        check({name, "_class"}, int'(class_o), cls);
        check({name, "_max"},   int'($signed(max_o)), mx);
        check({name, "_model"}, m_class * 1000 + m_max, cls * 1000 + mx);
    endtask

    int mode, extra;

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        tick();
        tick();
        check("rst_class", int'(class_o), 0);
        check("rst_max",   int'(max_o), 0);
        check("rst_valid", int'(valid_o), 0);
        check("rst_busy",  int'(busy_o), 0);
        check("rst_drop",  int'(drop_o), 0);
        rst = 1'b0;
        idle(2);

        // Tie at lanes 2 and 4 keeps the lower index
        lane_v = '{3, -5, 12, 7, 12, -128, 0};
        pulse();
        idle(B - 2);
        check("t027_not_yet", int'(valid_o), 0);
        tick();
        lit_result("t027", 2, 12);
        idle(1);
        check("t027_one_pulse", int'(valid_o), 0);

        // All-minimum vector
        lane_v = '{-128, -128, -128, -128, -128, -128, -128};
        pulse();
        idle(B - 1);
        lit_result("t028a", 0, -128);
        idle(1);

        // Maximum in the last lane
        lane_v = '{-1, -1, -1, -1, -1, -1, 127};
        pulse();
        idle(B - 1);
        lit_result("t028b", 6, 127);

        // Back-to-back at n and n+7 (this pulse lands on the edge after valid_o)
        lane_v = '{1, 2, 3, 4, 5, 6, 7};
        pulse();
        idle(B - 1);
        lit_result("t030a", 6, 7);
        lane_v = '{9, 9, 0, 0, 0, 0, 0};
        pulse();
        idle(B - 1);
        lit_result("t030b", 0, 9);
        check("t030_nodrop", int'(drop_o), 0);
        idle(1);

        // Second vector mid-scan is dropped
        lane_v = '{0, 0, 0, 50, 0, 0, 0};
        pulse();
        idle(2);
        lane_v = '{100, 100, 100, 100, 100, 100, 100};
        pulse();
        check("t029_drop", int'(drop_o), 1);
        idle(B - 4);
        lit_result("t029", 3, 50);
        idle(2);
        check("t029_sticky", int'(drop_o), 1);

        // A pulse on the edge that finishes the scan is still dropped
        do_reset();
        check("t030c_clr", int'(drop_o), 0);
        lane_v = '{4, 8, 2, 0, 0, 0, 0};
        pulse();
        idle(B - 2);
        lane_v = '{90, 0, 0, 0, 0, 0, 0};
        pulse();
        lit_result("t030c", 1, 8);
        check("t030c_drop", int'(drop_o), 1);
        idle(2);

        // Reset in the middle of a scan, then a fresh vector two edges later
        do_reset();
        lane_v = '{5, 60, 5, 5, 5, 5, 5};
        pulse();
        idle(2);
        do_reset();
        check("t031_class", int'(class_o), 0);
        check("t031_max",   int'(max_o), 0);
        check("t031_busy",  int'(busy_o), 0);
        check("t031_valid", int'(valid_o), 0);
        tick();
        lane_v = '{-3, -2, -7, -1, -9, -4, -5};
        pulse();
        idle(B - 1);
        lit_result("t031", 3, -1);
        idle(2);

        // Randomized vectors, spaced at least B cycles apart
        for (int n = 0; n < 10000; n++) begin
            for (int k = 0; k < B; k++) begin
                mode = $urandom_range(0, 2);
                case (mode)
                    0:       lane_v[k] = int'($urandom_range(0, 255)) - 128;
                    1:       lane_v[k] = int'($urandom_range(0, 4)) - 2;
                    default: begin
                        case ($urandom_range(0, 3))
                            0:       lane_v[k] = -128;
                            1:       lane_v[k] = -1;
                            2:       lane_v[k] = 0;
                            default: lane_v[k] = 127;
                        endcase
                    end
                endcase
            end
            extra = ($urandom_range(0, 7) == 0) ? 1 : 0;
            pulse();
            idle(B - 1 + extra);
        end
        check("rand_nodrop", int'(drop_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
